// File: rtl/spectrum_bars.sv
// Multi-band bar-graph pixel generator for the RGB LED panel: per-band levels with decay and
// peak hold, loaded tear-free through a one-entry staging buffer, rendered as double pixels.
module spectrum_bars #(
   parameter int unsigned COLS         = 32,
   parameter int unsigned HALF_ROWS    = 16,
   parameter int unsigned NCH          = 8,
   parameter int unsigned HW           = 6,
   parameter int unsigned DECAY_FRAMES = 2,
   parameter int unsigned PEAK_HOLD    = 4,
   parameter int unsigned GAP          = 1,
   localparam int unsigned AW          = $clog2(COLS * HALF_ROWS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mode,
   input  logic [NCH*HW-1:0]   heights,
   input  logic                heights_valid,
   output logic                heights_ready,
   input  logic [AW-1:0]       ram_address,
   output logic [47:0]         ram_data
);

   localparam int unsigned H   = 2 * HALF_ROWS;
   localparam int unsigned BW  = COLS / NCH;
   localparam int unsigned CW  = $clog2(COLS);
   localparam int unsigned RW  = AW - CW;
   localparam int unsigned BWL = $clog2(BW);
   localparam int unsigned NW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned DCW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
   localparam int unsigned PHW = $clog2(PEAK_HOLD + 1);

   logic [AW-1:0]  addr_q;
   logic [HW-1:0]  lvl_q  [NCH];
   logic [HW-1:0]  lvl_d  [NCH];
   logic [HW-1:0]  pk_q   [NCH];
   logic [HW-1:0]  pk_d   [NCH];
   logic [HW-1:0]  stg_q  [NCH];
   logic [HW-1:0]  stg_d  [NCH];
   logic [PHW-1:0] hold_q [NCH];
   logic [PHW-1:0] hold_d [NCH];
   logic [DCW-1:0] dcnt_q, dcnt_d;
   logic [23:0]    acc_q, acc_d;
   logic           full_q, full_d;
   logic           tick, dec;

   function automatic logic [HW-1:0] clamp(input logic [HW-1:0] f);
      return (f > HW'(H)) ? HW'(H) : f;
   endfunction

   function automatic logic [23:0] bar_px(input logic [HW-1:0] y, input logic [HW-1:0] lvl,
                                          input logic [HW-1:0] pk, input logic cyc,
                                          input logic [23:0] acc);
      if (lvl > y) begin
         if (cyc) return acc;
         if (y < HW'(H / 2)) return 24'h00FF00;
         if (y < HW'(3 * H / 4)) return 24'hFFFF00;
         return 24'hFF0000;
      end
      if (pk != '0 && {1'b0, pk} == {1'b0, y} + 1'b1) return 24'hFFFFFF;
      return 24'h000000;
   endfunction

   assign heights_ready = ~full_q;
   // addr_q doubles as the previous-address register for tick detection
   assign tick = (ram_address == '0) && (addr_q != '0);
   assign dec  = (dcnt_q == DCW'(DECAY_FRAMES - 1));

   always_comb begin
      dcnt_d = dcnt_q;
      acc_d  = acc_q;
      full_d = full_q;
      for (int k = 0; k < NCH; k++) begin
         lvl_d[k]  = lvl_q[k];
         pk_d[k]   = pk_q[k];
         hold_d[k] = hold_q[k];
         stg_d[k]  = stg_q[k];
      end
      if (tick) begin
         dcnt_d = dec ? '0 : dcnt_q + 1'b1;
         acc_d  = acc_q + 24'h010203;
         full_d = 1'b0;
         for (int k = 0; k < NCH; k++) begin
            if (full_q && stg_q[k] > lvl_q[k]) lvl_d[k] = stg_q[k];
            else if (dec && lvl_q[k] != '0) lvl_d[k] = lvl_q[k] - 1'b1;
            // peak follows the post-update level; in the final branch lvl_d < pk_q already
            if (lvl_d[k] >= pk_q[k]) begin
               pk_d[k]   = lvl_d[k];
               hold_d[k] = PHW'(PEAK_HOLD);
            end else if (hold_q[k] != '0) begin
               hold_d[k] = hold_q[k] - 1'b1;
            end else begin
               pk_d[k] = pk_q[k] - 1'b1;
            end
         end
      end
      if (heights_valid && !full_q) begin
         full_d = 1'b1;
         for (int k = 0; k < NCH; k++) stg_d[k] = clamp(heights[k*HW +: HW]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q <= '1;
         dcnt_q <= '0;
         acc_q  <= '0;
         full_q <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            lvl_q[k]  <= '0;
            pk_q[k]   <= '0;
            hold_q[k] <= '0;
            stg_q[k]  <= '0;
         end
      end else begin
         addr_q <= ram_address;
         dcnt_q <= dcnt_d;
         acc_q  <= acc_d;
         full_q <= full_d;
         for (int k = 0; k < NCH; k++) begin
            lvl_q[k]  <= lvl_d[k];
            pk_q[k]   <= pk_d[k];
            hold_q[k] <= hold_d[k];
            stg_q[k]  <= stg_d[k];
         end
      end
   end

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [NW-1:0] band;
   logic [HW-1:0] y_top, y_bot;
   logic [23:0]   px_top, px_bot;
   logic          gap;

   always_comb begin
      col    = addr_q[CW-1:0];
      row    = addr_q[AW-1:CW];
      band   = NW'(col >> BWL);
      y_top  = HW'(H - 1) - HW'(row);
      y_bot  = HW'(HALF_ROWS - 1) - HW'(row);
      px_top = bar_px(y_top, lvl_q[band], pk_q[band], mode[0], acc_q);
      px_bot = bar_px(y_bot, lvl_q[band], pk_q[band], mode[0], acc_q);
      gap    = (GAP != 0) && ((col & CW'(BW - 1)) == CW'(BW - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ram_data <= '0;
      end else begin
         case (mode)
            2'd0:    ram_data <= '0;
            2'd1:    ram_data <= {2{24'hB3FFFF}};
            default: ram_data <= gap ? '0 : {px_bot, px_top};
         endcase
      end
   end

endmodule

// File: tb/tb_spectrum_bars.sv
// Directed bench for spectrum_bars: a frame-level reference model pushes expected words into
// a queue as addresses are driven; words are popped and compared two clocks later.
module tb_spectrum_bars;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [47:0] heights;
   logic        heights_valid;
   logic        heights_ready;
   logic [8:0]  ram_address;
   logic [47:0] ram_data;

   always #5 clk = ~clk;

   spectrum_bars dut (
      .clk           (clk),
      .rst           (rst),
      .mode          (mode),
      .heights       (heights),
      .heights_valid (heights_valid),
      .heights_ready (heights_ready),
      .ram_address   (ram_address),
      .ram_data      (ram_data)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [47:0] m2;
      logic [47:0] m3;
      logic [1:0]  md;
      bit          chk;
      int          a;
   } exp_t;
   exp_t q[$];

   // reference model state
   int          lvl[8], pk[8], hold[8], stg[8];
   int          dcnt, prev;
   bit          full;
   logic [23:0] acc;

   function automatic logic [47:0] hw(input int b, input int v);
      logic [47:0] w;
      w = 48'(v & 63);
      return w << (6 * b);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         lvl[k] = 0; pk[k] = 0; hold[k] = 0; stg[k] = 0;
      end
      dcnt = 0; prev = 511; full = 0; acc = 24'h0;
   endtask

   task automatic model_frame();
      bit d;
      dcnt = (dcnt + 1) % 2;
      d = (dcnt == 0);
      acc = acc + 24'h010203;
      for (int k = 0; k < 8; k++) begin
         if (full && stg[k] > lvl[k]) lvl[k] = stg[k];
         else if (d && lvl[k] > 0) lvl[k] = lvl[k] - 1;
         if (lvl[k] >= pk[k]) begin
            pk[k] = lvl[k]; hold[k] = 4;
         end else if (hold[k] > 0) begin
            hold[k] = hold[k] - 1;
         end else begin
            pk[k] = (pk[k] - 1 > lvl[k]) ? pk[k] - 1 : lvl[k];
         end
      end
      full = 0;
   endtask

   function automatic logic [23:0] mcol(input int y, input int l, input int p, input bit cyc);
      if (y < l) begin
         if (cyc) return acc;
         if (y < 16) return 24'h00FF00;
         if (y < 24) return 24'hFFFF00;
         return 24'hFF0000;
      end
      if (p > 0 && y == p - 1) return 24'hFFFFFF;
      return 24'h000000;
   endfunction

   function automatic logic [47:0] mword(input int a, input bit cyc);
      int c, r, b;
      c = a % 32; r = a / 32; b = c / 4;
      if (c % 4 == 3) return 48'h0;
      return {mcol(15 - r, lvl[b], pk[b], cyc), mcol(31 - r, lvl[b], pk[b], cyc)};
   endfunction

   function automatic logic [47:0] pick(input exp_t e);
      case (e.md)
         2'd0:    return 48'h0;
         2'd1:    return {2{24'hB3FFFF}};
         2'd2:    return e.m2;
         default: return e.m3;
      endcase
   endfunction

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input int a, input bit v, input logic [47:0] h, input logic [1:0] md,
                       input bit chk);
      exp_t e;
      bit   rdy;
      @(negedge clk);
      if (q.size() == 2) begin
         e = q.pop_front();
         if (e.chk) check($sformatf("data a=%0d md=%0d", e.a, e.md), ram_data, pick(e));
      end
      // the youngest word is registered on the coming edge, with the mode driven now
      if (q.size() > 0) q[q.size()-1].md = md;
      if (chk) check($sformatf("ready a=%0d", a), {47'h0, heights_ready}, {47'h0, !full});
      ram_address   = 9'(a);
      heights_valid = v;
      heights       = h;
      mode          = md;
      rdy = !full;
      if (a == 0 && prev != 0) model_frame();
      if (v && rdy) begin
         for (int k = 0; k < 8; k++) begin
            stg[k] = int'(h[6*k +: 6]);
            if (stg[k] > 32) stg[k] = 32;
         end
         full = 1;
      end
      prev = a;
      e.m2 = mword(a, 0); e.m3 = mword(a, 1); e.md = md; e.chk = chk; e.a = a;
      q.push_back(e);
   endtask

   task automatic sweep(input logic [1:0] md, input int load_at, input logic [47:0] h,
                        input bit vall, input int last = 511);
      for (int a = 0; a <= last; a++) step(a, vall || (a == load_at), h, md, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; ram_address = 9'h1FF; heights_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("reset_data", ram_data, 48'h0);
         check("reset_ready", {47'h0, heights_ready}, 48'h1);
      end
      model_reset();
      q.delete();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; mode = 2'd1; heights = '0; heights_valid = 1'b0; ram_address = 9'h1FF;
      model_reset();
      do_reset();
      sweep(2'd1, -1, '0, 1'b0);                     // home mode
      sweep(2'd2, 300, hw(0, 20), 1'b0);             // load staged mid-frame
      sweep(2'd2, -1, '0, 1'b0);                     // band 0 at 20
      sweep(2'd2, 100, hw(0, 63) | hw(1, 10), 1'b0); // clamp + tear-free load
      sweep(2'd2, -1, '0, 1'b0);
      repeat (7) sweep(2'd2, -1, '0, 1'b0);          // decay and peak hold
      sweep(2'd2, 50, hw(2, 5), 1'b0);
      sweep(2'd2, -1, hw(2, 30), 1'b1);              // valid held, full at tick
      sweep(2'd2, -1, hw(2, 12) | hw(3, 7), 1'b1);
      repeat (3) step(0, 1'b0, '0, 2'd2, 1'b1);      // held address 0: single tick
      sweep(2'd2, -1, '0, 1'b0, 200);
      do_reset();                                    // reset mid-frame
      sweep(2'd3, 10, hw(0, 20) | hw(5, 3), 1'b0);
      repeat (2) sweep(2'd3, -1, '0, 1'b0);          // colour cycling
      sweep(2'd0, -1, '0, 1'b0);
      sweep(2'd3, -1, '0, 1'b0, 40);
      step(41, 1'b0, '0, 2'd0, 1'b1);                // mode change lands two clocks on
      step(42, 1'b0, '0, 2'd0, 1'b1);
      step(43, 1'b0, '0, 2'd0, 1'b0);
      step(44, 1'b0, '0, 2'd0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
